// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, PC step and the FIFO entry type for the fetch stage
package fetch_pkg;
  localparam int FETCH_ADDR_W = 64;
  localparam int FETCH_INST_W = 32;
  localparam int PC_STEP = 4;
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of DEPTH entries with flush taking priority over push/pop
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter type T = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  T r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic w_pop;
  // status and head view; popping an empty buffer is ignored
  always_comb begin
    empty = r_count == '0;
    full = r_count == CW'(DEPTH);
    w_pop = pop & ~empty;
    head = r_mem[r_rp];
    count = r_count;
  end
  // payload storage needs no reset: it is only visible through a valid head
  always_ff @(posedge clk)
    if (push && !flush) r_mem[r_wp] <= push_data;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wp <= r_wp + PW'(1);
      if (w_pop) r_rp <= r_rp + PW'(1);
      r_count <= r_count + CW'(push) - CW'(w_pop);
    end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full && !flush));
endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: sequential PC generation, credit-limited imem requests, buffered hand-off to decode
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int INST_W = FETCH_INST_W,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_ready,
  input  logic [INST_W-1:0]        imem_rdata,
  input  logic                     redir_valid,
  input  logic [ADDR_W-1:0]        redir_pc,
  output logic                     if_valid,
  input  logic                     if_ready,
  output logic [ADDR_W-1:0]        if_pc,
  output logic [ADDR_W-1:0]        if_pc_plus4,
  output logic [INST_W-1:0]        if_inst,
  output logic [$clog2(DEPTH):0]   if_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;
  logic [ADDR_W-1:0] r_pc, r_req_pc;
  logic r_inflight;
  logic w_pop, w_push, w_accept, w_empty, w_full;
  logic [CW:0] w_demand;
  entry_t w_head, w_push_data;
  // a request is allowed only if its response is guaranteed a free slot once this cycle's pop and pending push settle
  always_comb begin
    w_pop = ~w_empty & if_ready & ~redir_valid;
    w_push = r_inflight & ~redir_valid;
    w_demand = {1'b0, if_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
    imem_req = rst & ~redir_valid & (w_demand < (CW+1)'(DEPTH));
    w_accept = imem_req & imem_ready;
    imem_addr = r_pc;
    w_push_data = '{pc: r_req_pc, inst: imem_rdata};
    if_valid = ~w_empty;
    if_pc = w_head.pc;
    if_inst = w_head.inst;
    if_pc_plus4 = w_head.pc + ADDR_W'(PC_STEP);
  end
  // fetch PC, outstanding-request flag and its PC; a redirect discards the outstanding response
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_pc <= RESET_PC;
      r_req_pc <= '0;
      r_inflight <= 1'b0;
    end else if (redir_valid) begin
      r_pc <= redir_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_pc <= r_pc + ADDR_W'(PC_STEP);
        r_req_pc <= r_pc;
      end
    end
  fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(w_push),
    .push_data(w_push_data),
    .pop(w_pop),
    .flush(redir_valid),
    .head(w_head),
    .count(if_count),
    .empty(w_empty),
    .full(w_full)
  );
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: queue-based reference model with per-cycle compare plus directed literal checks
module tb_fetch_queue_unit;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic imem_req, if_valid;
  logic imem_ready = 1'b0, redir_valid = 1'b0, if_ready = 1'b0;
  logic [63:0] imem_addr, if_pc, if_pc_plus4;
  logic [63:0] redir_pc = '0;
  logic [31:0] imem_rdata = '0, if_inst;
  logic [2:0] if_count;
  logic w_req, w_valid;
  logic [63:0] w_addr, w_pc, w_pc4;
  logic [31:0] w_inst;
  logic [2:0] w_count;
  fetch_queue_unit #(.ADDR_W(64), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .redir_valid(redir_valid), .redir_pc(redir_pc), .if_valid(if_valid),
    .if_ready(if_ready), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_inst(if_inst), .if_count(if_count)
  );
  fetch_queue_unit #(.ADDR_W(64), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1),
    .imem_rdata(32'hCAFE_F00D), .redir_valid(1'b0), .redir_pc(64'h0), .if_valid(w_valid),
    .if_ready(1'b1), .if_pc(w_pc), .if_pc_plus4(w_pc4), .if_inst(w_inst), .if_count(w_count)
  );
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  typedef struct {logic [63:0] pc; logic [31:0] inst;} ent_t;
  ent_t q[$];
  logic [63:0] m_pc = '0, m_req_pc = '0;
  bit m_infl = 1'b0;
  function automatic bit m_pop();
    return q.size() > 0 && if_ready && !redir_valid;
  endfunction
  function automatic bit m_req();
    return rst && !redir_valid && (q.size() + int'(m_infl) - int'(m_pop())) < DEPTH;
  endfunction
  always @(posedge clk or negedge rst) begin
    bit p, acc;
    p = m_pop();
    acc = m_req() && imem_ready;
    if (!rst) begin
      q.delete();
      m_pc = '0;
      m_req_pc = '0;
      m_infl = 1'b0;
    end else if (redir_valid) begin
      q.delete();
      m_infl = 1'b0;
      m_pc = redir_pc;
    end else begin
      if (p) void'(q.pop_front());
      if (m_infl) q.push_back('{m_req_pc, 32'(m_req_pc >> 2)});
      if (acc) begin
        m_req_pc = m_pc;
        m_pc = m_pc + 64'd4;
      end
      m_infl = acc;
    end
  end
  logic acc_n = 1'b0;
  logic [63:0] acc_addr = '0;
  always @(negedge clk) begin
    bit er;
    er = m_req();
    chk("imem_req", imem_req, er);
    if (er) chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", if_valid, q.size() > 0);
    chk("if_count", if_count, q.size());
    chk("count_bound", if_count <= DEPTH, 1);
    if (q.size() > 0) begin
      chk("if_pc", if_pc, q[0].pc);
      chk("if_pc_plus4", if_pc_plus4, q[0].pc + 64'd4);
      chk("if_inst", if_inst, q[0].inst);
    end
    acc_n = imem_req & imem_ready;
    acc_addr = imem_addr;
  end
  always @(posedge clk) begin
    #1 imem_rdata = acc_n ? 32'(acc_addr >> 2) : 32'hDEAD_BEEF;
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int k;
    #1 rst = 1'b0;
    tick(3);
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_count", if_count, 0);
    tick(1);
    rst = 1'b1; imem_ready = 1'b1; if_ready = 1'b1;
    @(negedge clk);
    chk("c0_addr", imem_addr, 64'h0);
    chk("c0_wrap_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("c0_wrap_req", w_req, 1);
    tick(1);
    @(negedge clk);
    chk("c1_valid", if_valid, 0);
    tick(1);
    @(negedge clk);
    chk("c2_pc", if_pc, 64'h0);
    chk("c2_wrap_pc", w_pc, 64'hFFFF_FFFF_FFFF_FFF8);
    tick(1);
    @(negedge clk);
    chk("c3_pc", if_pc, 64'h4);
    chk("c3_inst", if_inst, 32'h1);
    chk("c3_wrap_pc", w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("c3_wrap_pc4", w_pc4, 64'h0);
    chk("c3_wrap_inst", w_inst, 32'hCAFE_F00D);
    chk("c3_wrap_count", w_count, 1);
    tick(1);
    @(negedge clk);
    chk("c4_pc", if_pc, 64'h8);
    chk("c4_inst", if_inst, 32'h2);
    chk("c4_wrap_pc", w_pc, 64'h0);
    chk("c4_wrap_valid", w_valid, 1);
    tick(6);
    if_ready = 1'b0;
    tick(8);
    @(negedge clk);
    chk("stall_count", if_count, 4);
    chk("stall_req", imem_req, 0);
    tick(1);
    if_ready = 1'b1;
    tick(8);
    if_ready = 1'b0;
    for (int i = 0; i < 20 && !(q.size() == 3 && m_infl); i++) tick(1);
    redir_valid = 1'b1; redir_pc = 64'h100; if_ready = 1'b1;
    @(negedge clk);
    chk("t0_count", if_count, 3);
    chk("t0_req", imem_req, 0);
    tick(1);
    redir_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid", if_valid, 0);
    chk("t1_addr", imem_addr, 64'h100);
    chk("t1_req", imem_req, 1);
    tick(1);
    @(negedge clk);
    chk("t2_valid", if_valid, 0);
    tick(1);
    @(negedge clk);
    chk("t3_valid", if_valid, 1);
    chk("t3_pc", if_pc, 64'h100);
    tick(4);
    redir_valid = 1'b1; redir_pc = 64'h40;
    @(negedge clk);
    chk("rp_valid", if_valid, 1);
    tick(1);
    redir_valid = 1'b0;
    @(negedge clk);
    chk("rp_count", if_count, 0);
    tick(5);
    redir_valid = 1'b1; redir_pc = 64'h200;
    tick(1);
    redir_pc = 64'h300;
    tick(1);
    redir_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!if_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("dbl_valid", if_valid, 1);
    chk("dbl_pc", if_pc, 64'h300);
    chk("dbl_latency", k, 2);
    tick(1);
    for (int i = 0; i < 150; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      if_ready = 1'($urandom_range(0, 1));
      redir_valid = $urandom_range(0, 19) == 0;
      redir_pc = 64'($urandom_range(0, 1023)) << 2;
      tick(1);
    end
    redir_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("mrst_valid", if_valid, 0);
    chk("mrst_req", imem_req, 0);
    tick(1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_addr", imem_addr, 64'h0);
    chk("mrst_count", if_count, 0);
    tick(1);
    for (int i = 0; i < 150; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      if_ready = 1'($urandom_range(0, 1));
      redir_valid = $urandom_range(0, 19) == 0;
      redir_pc = 64'($urandom_range(0, 1023)) << 2;
      tick(1);
    end
    redir_valid = 1'b0;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
